// File: rtl/maze_mem.sv
// maze_mem: responder side of the maze access interface.
// Holds a wall map and a visited-path map for a maze of up to 64x64 cells.
// After reset the maps are swept clear one cell per cycle, then a host
// loads the walls. A start pulse hands control to the solver, which reads
// walls with a one-cycle registered latency and marks cells as visited.
module maze_mem #(
   parameter int unsigned N_ROWS = 64,
   parameter int unsigned N_COLS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  row,
   input  logic [5:0]  col,
   input  logic        maze_oe,
   input  logic        maze_we,
   input  logic        done,
   output logic        maze_in,
   input  logic        load_en,
   input  logic [5:0]  load_row,
   input  logic [5:0]  load_col,
   input  logic        load_wall,
   input  logic        start,
   output logic        mem_ready,
   output logic        running,
   input  logic [5:0]  dbg_row,
   input  logic [5:0]  dbg_col,
   output logic        dbg_path,
   output logic [12:0] visited_cnt,
   output logic        exit_found,
   output logic [5:0]  exit_row,
   output logic [5:0]  exit_col
);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_LOAD,
      S_RUN
   } state_t;

   localparam logic [6:0]  LP_ROWS     = 7'(N_ROWS);
   localparam logic [6:0]  LP_COLS     = 7'(N_COLS);
   localparam logic [5:0]  LP_LAST_ROW = 6'(N_ROWS - 1);
   localparam logic [5:0]  LP_LAST_COL = 6'(N_COLS - 1);
   localparam logic [12:0] LP_CNT_MAX  = 13'd4096;

   state_t      r_state;
   logic [5:0]  r_clr_row;
   logic [5:0]  r_clr_col;
   logic        r_maze_in;
   logic        r_mem_ready;
   logic        r_running;
   logic [12:0] r_visited;
   logic        r_exit_found;
   logic [5:0]  r_exit_row;
   logic [5:0]  r_exit_col;

   // Maps are indexed {row, col}; cells outside N_ROWS x N_COLS are never
   // swept, so every access to them is gated by a range check.
   logic        r_wall [4096];
   logic        r_path [4096];

   logic [11:0] w_sol_idx;
   logic        w_sol_in;
   logic [11:0] w_load_idx;
   logic        w_load_in;
   logic [11:0] w_dbg_idx;
   logic        w_dbg_in;
   logic [11:0] w_clr_idx;
   logic        w_clr_last;
   logic        w_run_we;
   logic        w_new_visit;

   assign w_sol_idx   = {row, col};
   assign w_sol_in    = ({1'b0, row} < LP_ROWS) && ({1'b0, col} < LP_COLS);
   assign w_load_idx  = {load_row, load_col};
   assign w_load_in   = ({1'b0, load_row} < LP_ROWS) && ({1'b0, load_col} < LP_COLS);
   assign w_dbg_idx   = {dbg_row, dbg_col};
   assign w_dbg_in    = ({1'b0, dbg_row} < LP_ROWS) && ({1'b0, dbg_col} < LP_COLS);
   assign w_clr_idx   = {r_clr_row, r_clr_col};
   assign w_clr_last  = (r_clr_row == LP_LAST_ROW) && (r_clr_col == LP_LAST_COL);
   assign w_run_we    = (r_state == S_RUN) && maze_we && w_sol_in;
   assign w_new_visit = w_run_we && !r_path[w_sol_idx];

   assign maze_in     = r_maze_in;
   assign mem_ready   = r_mem_ready;
   assign running     = r_running;
   assign visited_cnt = r_visited;
   assign exit_found  = r_exit_found;
   assign exit_row    = r_exit_row;
   assign exit_col    = r_exit_col;
   assign dbg_path    = w_dbg_in ? r_path[w_dbg_idx] : 1'b0;

   // Control FSM: clear sweep, host load, solver run; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_CLEAR;
         r_clr_row    <= '0;
         r_clr_col    <= '0;
         r_maze_in    <= 1'b1;
         r_mem_ready  <= 1'b0;
         r_running    <= 1'b0;
         r_visited    <= '0;
         r_exit_found <= 1'b0;
         r_exit_row   <= '0;
         r_exit_col   <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               if (w_clr_last) begin
                  r_state     <= S_LOAD;
                  r_mem_ready <= 1'b1;
               end else if (r_clr_col == LP_LAST_COL) begin
                  r_clr_col <= '0;
                  r_clr_row <= r_clr_row + 6'd1;
               end else begin
                  r_clr_col <= r_clr_col + 6'd1;
               end
            end
            S_LOAD: begin
               if (start) begin
                  r_state     <= S_RUN;
                  r_mem_ready <= 1'b0;
                  r_running   <= 1'b1;
               end
            end
            S_RUN: begin
               if (maze_oe) begin
                  r_maze_in <= w_sol_in ? r_wall[w_sol_idx] : 1'b1;
               end
               if (w_new_visit && (r_visited != LP_CNT_MAX)) begin
                  r_visited <= r_visited + 13'd1;
               end
               if (done && !r_exit_found) begin
                  r_exit_found <= 1'b1;
                  r_exit_row   <= row;
                  r_exit_col   <= col;
               end
            end
            default: begin
               r_state <= S_CLEAR;
            end
         endcase
      end
   end

   // Map storage: sweep during clear, wall loads in LOAD, visit marks in RUN.
   always_ff @(posedge clk) begin
      case (r_state)
         S_CLEAR: begin
            r_wall[w_clr_idx] <= 1'b0;
            r_path[w_clr_idx] <= 1'b0;
         end
         S_LOAD: begin
            if (load_en && w_load_in) begin
               r_wall[w_load_idx] <= load_wall;
            end
         end
         S_RUN: begin
            if (w_run_we) begin
               r_path[w_sol_idx] <= 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_maze_mem.sv
// Self-checking bench for maze_mem: a 64x64 instance and an 8x64 instance,
// a cell-level reference model updated on each rising edge, a per-cycle
// comparison on the falling edge, and directed literal expectations.
module tb_maze_mem;

   localparam int NR [2] = '{64, 8};
   localparam int NC [2] = '{64, 64};

   logic clk;
   logic rst_n;

   logic [5:0]  s_row  [2];
   logic [5:0]  s_col  [2];
   logic        s_oe   [2];
   logic        s_we   [2];
   logic        s_done [2];
   logic        s_len  [2];
   logic [5:0]  s_lrow [2];
   logic [5:0]  s_lcol [2];
   logic        s_lwall[2];
   logic        s_start[2];
   logic [5:0]  s_drow [2];
   logic [5:0]  s_dcol [2];

   logic        o_in   [2];
   logic        o_ready[2];
   logic        o_run  [2];
   logic        o_dbg  [2];
   logic [12:0] o_cnt  [2];
   logic        o_found[2];
   logic [5:0]  o_erow [2];
   logic [5:0]  o_ecol [2];

   int n_chk = 0;
   int n_err = 0;

   maze_mem #(.N_ROWS(64), .N_COLS(64)) u_a (
      .clk(clk), .rst_n(rst_n),
      .row(s_row[0]), .col(s_col[0]), .maze_oe(s_oe[0]), .maze_we(s_we[0]),
      .done(s_done[0]), .maze_in(o_in[0]),
      .load_en(s_len[0]), .load_row(s_lrow[0]), .load_col(s_lcol[0]),
      .load_wall(s_lwall[0]), .start(s_start[0]),
      .mem_ready(o_ready[0]), .running(o_run[0]),
      .dbg_row(s_drow[0]), .dbg_col(s_dcol[0]), .dbg_path(o_dbg[0]),
      .visited_cnt(o_cnt[0]), .exit_found(o_found[0]),
      .exit_row(o_erow[0]), .exit_col(o_ecol[0])
   );

   maze_mem #(.N_ROWS(8), .N_COLS(64)) u_b (
      .clk(clk), .rst_n(rst_n),
      .row(s_row[1]), .col(s_col[1]), .maze_oe(s_oe[1]), .maze_we(s_we[1]),
      .done(s_done[1]), .maze_in(o_in[1]),
      .load_en(s_len[1]), .load_row(s_lrow[1]), .load_col(s_lcol[1]),
      .load_wall(s_lwall[1]), .start(s_start[1]),
      .mem_ready(o_ready[1]), .running(o_run[1]),
      .dbg_row(s_drow[1]), .dbg_col(s_dcol[1]), .dbg_path(o_dbg[1]),
      .visited_cnt(o_cnt[1]), .exit_found(o_found[1]),
      .exit_row(o_erow[1]), .exit_col(o_ecol[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 = sweeping, 1 = accepting loads, 2 = solver running
   bit m_wall [2][64][64];
   bit m_path [2][64][64];
   int m_phase[2];
   int m_left [2];
   int m_cnt  [2];
   bit m_in   [2];
   bit m_found[2];
   int m_erow [2];
   int m_ecol [2];

   function automatic bit inr(input int k, input int r, input int c);
      return (r < NR[k]) && (c < NC[k]);
   endfunction

   task automatic model_reset(input int k);
      m_phase[k] = 0;
      m_left[k]  = NR[k] * NC[k];
      m_cnt[k]   = 0;
      m_in[k]    = 1'b1;
      m_found[k] = 1'b0;
      m_erow[k]  = 0;
      m_ecol[k]  = 0;
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++) begin
            m_wall[k][r][c] = 1'b0;
            m_path[k][r][c] = 1'b0;
         end
   endtask

   task automatic model_step(input int k);
      int r, c;
      r = int'(s_row[k]);
      c = int'(s_col[k]);
      case (m_phase[k])
         0: begin
            m_left[k]--;
            if (m_left[k] == 0) m_phase[k] = 1;
         end
         1: begin
            if (s_len[k] && inr(k, int'(s_lrow[k]), int'(s_lcol[k])))
               m_wall[k][s_lrow[k]][s_lcol[k]] = s_lwall[k];
            if (s_start[k]) m_phase[k] = 2;
         end
         default: begin
            if (s_oe[k]) m_in[k] = inr(k, r, c) ? m_wall[k][r][c] : 1'b1;
            if (s_we[k] && inr(k, r, c) && !m_path[k][r][c]) begin
               m_path[k][r][c] = 1'b1;
               if (m_cnt[k] < 4096) m_cnt[k]++;
            end
            if (s_done[k] && !m_found[k]) begin
               m_found[k] = 1'b1;
               m_erow[k]  = r;
               m_ecol[k]  = c;
            end
         end
      endcase
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("cmp%0d_maze_in", k),   int'(o_in[k]),    int'(m_in[k]));
            chk($sformatf("cmp%0d_mem_ready", k), int'(o_ready[k]), int'(m_phase[k] == 1));
            chk($sformatf("cmp%0d_running", k),   int'(o_run[k]),   int'(m_phase[k] == 2));
            chk($sformatf("cmp%0d_visited", k),   int'(o_cnt[k]),   m_cnt[k]);
            chk($sformatf("cmp%0d_exit_found", k), int'(o_found[k]), int'(m_found[k]));
            chk($sformatf("cmp%0d_exit_row", k),  int'(o_erow[k]),  m_erow[k]);
            chk($sformatf("cmp%0d_exit_col", k),  int'(o_ecol[k]),  m_ecol[k]);
            if (m_phase[k] != 0) begin
               chk($sformatf("cmp%0d_dbg_path", k), int'(o_dbg[k]),
                   inr(k, int'(s_drow[k]), int'(s_dcol[k])) ?
                   int'(m_path[k][s_drow[k]][s_dcol[k]]) : 0);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      s_oe[k] = 1'b0; s_we[k] = 1'b0; s_done[k] = 1'b0;
      s_len[k] = 1'b0; s_start[k] = 1'b0; s_lwall[k] = 1'b0;
   endtask

   task automatic sol(input int k, input int r, input int c,
                      input bit oe, input bit we, input bit dn);
      idle(k);
      s_row[k] = 6'(r); s_col[k] = 6'(c);
      s_oe[k] = oe; s_we[k] = we; s_done[k] = dn;
      tick();
      idle(k);
   endtask

   task automatic dbg(input int k, input int r, input int c, input int exp, input string nm);
      s_drow[k] = 6'(r); s_dcol[k] = 6'(c);
      #1;
      chk(nm, int'(o_dbg[k]), exp);
   endtask

   task automatic wait_ready(output int na, output int nb);
      na = 0; nb = 0;
      while (!o_ready[0] && na < 5000) begin
         tick();
         na++;
         if (o_ready[1] && nb == 0) nb = na;
      end
   endtask

   int na, nb;

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         idle(k);
         s_row[k] = '0; s_col[k] = '0; s_lrow[k] = '0; s_lcol[k] = '0;
         s_drow[k] = '0; s_dcol[k] = '0;
      end
      repeat (3) tick();
      chk("rst_maze_in", int'(o_in[0]), 1);
      chk("rst_mem_ready", int'(o_ready[0]), 0);
      chk("rst_running", int'(o_run[0]), 0);
      chk("rst_visited", int'(o_cnt[0]), 0);

      rst_n = 1'b1;
      wait_ready(na, nb);
      chk("clear_cycles_64x64", na, 4096);
      chk("clear_cycles_8x64", nb, 512);

      dbg(0, 0, 0, 0, "dbg_clear_0_0");
      dbg(0, 63, 63, 0, "dbg_clear_63_63");
      dbg(0, 17, 42, 0, "dbg_clear_17_42");

      // LOAD: solver accesses must be inert; a load lands with start in one cycle
      s_row[0] = 6'd3; s_col[0] = 6'd3; s_oe[0] = 1'b1; s_we[0] = 1'b1;
      s_len[0] = 1'b1; s_lrow[0] = 6'd5; s_lcol[0] = 6'd5; s_lwall[0] = 1'b1;
      tick();
      idle(0);
      chk("load_maze_in_forced", int'(o_in[0]), 1);
      s_len[0] = 1'b1; s_lrow[0] = 6'd7; s_lcol[0] = 6'd7; s_lwall[0] = 1'b1;
      s_start[0] = 1'b1;
      tick();
      idle(0);
      chk("start_running", int'(o_run[0]), 1);
      chk("start_ready_low", int'(o_ready[0]), 0);

      // RUN: reads with one cycle latency, hold when oe low
      sol(0, 5, 5, 1, 0, 0); chk("rd_wall_5_5", int'(o_in[0]), 1);
      sol(0, 5, 6, 1, 0, 0); chk("rd_free_5_6", int'(o_in[0]), 0);
      sol(0, 7, 7, 1, 0, 0); chk("rd_load_with_start", int'(o_in[0]), 1);
      sol(0, 5, 6, 1, 0, 0); chk("rd_free_again", int'(o_in[0]), 0);
      sol(0, 5, 5, 0, 0, 0); chk("rd_hold", int'(o_in[0]), 0);

      // loads and start are ignored while running
      s_len[0] = 1'b1; s_lrow[0] = 6'd5; s_lcol[0] = 6'd6; s_lwall[0] = 1'b1;
      s_start[0] = 1'b1;
      tick();
      idle(0);
      sol(0, 5, 6, 1, 0, 0); chk("run_load_ignored", int'(o_in[0]), 0);

      // visit marks: repeated writes count once
      sol(0, 10, 10, 0, 1, 0);
      sol(0, 10, 10, 0, 1, 0);
      sol(0, 10, 10, 0, 1, 0);
      sol(0, 10, 11, 0, 1, 0);
      chk("visited_two", int'(o_cnt[0]), 2);
      dbg(0, 10, 10, 1, "dbg_path_10_10");
      dbg(0, 10, 11, 1, "dbg_path_10_11");
      dbg(0, 3, 3, 0, "dbg_load_we_ignored");

      // read and write on the same cell in one cycle
      sol(0, 5, 5, 1, 1, 0);
      chk("oe_we_read_wall", int'(o_in[0]), 1);
      chk("oe_we_count", int'(o_cnt[0]), 3);

      // exit latch is sticky
      sol(0, 0, 33, 0, 0, 1);
      sol(0, 63, 1, 0, 0, 1);
      chk("exit_found", int'(o_found[0]), 1);
      chk("exit_row", int'(o_erow[0]), 0);
      chk("exit_col", int'(o_ecol[0]), 33);

      sol(0, 1, 1, 0, 1, 0);
      sol(0, 63, 63, 0, 1, 0);
      chk("visited_five", int'(o_cnt[0]), 5);

      // 8-row instance: out-of-range rows read as wall and drop writes
      s_start[1] = 1'b1;
      tick();
      idle(1);
      sol(1, 0, 0, 1, 0, 0);  chk("b_rd_free", int'(o_in[1]), 0);
      sol(1, 8, 0, 1, 0, 0);  chk("b_rd_oob_row", int'(o_in[1]), 1);
      sol(1, 8, 0, 0, 1, 0);  chk("b_we_oob_cnt", int'(o_cnt[1]), 0);
      dbg(1, 8, 0, 0, "b_dbg_oob");
      sol(1, 7, 63, 0, 1, 0); chk("b_we_edge_cnt", int'(o_cnt[1]), 1);
      dbg(1, 7, 63, 1, "b_dbg_edge");

      // asynchronous reset mid-run
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_visited", int'(o_cnt[0]), 0);
      chk("arst_running", int'(o_run[0]), 0);
      chk("arst_maze_in", int'(o_in[0]), 1);
      chk("arst_exit_found", int'(o_found[0]), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_ready(na, nb);
      chk("reclear_cycles_64x64", na, 4096);
      dbg(0, 10, 10, 0, "dbg_reclear_10_10");
      dbg(0, 63, 63, 0, "dbg_reclear_63_63");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/maze_mem.md
Name: maze_mem

Overview:
- Responder end of the maze access interface: holds the wall map and the visited-path map of a maze up to 64x64 cells.
- Answers solver reads (maze_oe) with a registered wall bit on maze_in, and records solver writes (maze_we) as visited cells.
- Latches the exit coordinates when the solver raises done.
- Wall map is loaded by the testbench/host before the run; path map is readable through a debug port.

Parameters:
N_ROWS, 64, number of valid rows (1..64); rows >= N_ROWS read as wall
N_COLS, 64, number of valid columns (1..64); cols >= N_COLS read as wall

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
row  input  6  solver-selected row
col  input  6  solver-selected column
maze_oe  input  1  solver read enable, synchronous
maze_we  input  1  solver write enable (mark visited), synchronous
done  input  1  solver exit-found flag
maze_in  output  1  registered wall bit for last read (1 = wall, 0 = free)
load_en  input  1  write one wall-map cell (LOAD state only)
load_row  input  6  wall-map load row
load_col  input  6  wall-map load column
load_wall  input  1  wall value to store
start  input  1  one-cycle pulse: LOAD -> RUN
mem_ready  output  1  high in LOAD (map cleared, accepting loads)
running  output  1  high in RUN
dbg_row  input  6  debug read row
dbg_col  input  6  debug read column
dbg_path  output  1  combinational path-map bit at [dbg_row, dbg_col]; 0 if out of range
visited_cnt  output  13  number of distinct cells marked visited, saturates at 4096
exit_found  output  1  sticky: exit latched
exit_row  output  6  latched exit row
exit_col  output  6  latched exit column

Behaviour:
- Reset (async, rst_n low): state = CLEAR, clear counter = 0, maze_in = 1, mem_ready = 0, running = 0, visited_cnt = 0, exit_found = 0, exit_row = 0, exit_col = 0. Map contents are not reset asynchronously; CLEAR sweeps them.
- CLEAR:
  - One cell per cycle, row-major, from (0,0) to (N_ROWS-1, N_COLS-1).
  - Each swept cell gets wall = 0, path = 0.
  - After the last cell, go to LOAD. Duration is exactly N_ROWS*N_COLS cycles (4096 by default).
  - All inputs are ignored during CLEAR.
- LOAD:
  - mem_ready = 1.
  - load_en writes wall[load_row][load_col] = load_wall at the clock edge; out-of-range addresses are dropped.
  - start moves to RUN on the next edge. If load_en and start arrive in the same cycle, the load is applied, then RUN.
- RUN:
  - running = 1. load_en and start are ignored.
  - Read: if maze_oe is high at edge N, maze_in at edge N is set to wall[row][col]. This gives one cycle of latency, so the solver samples it in the following state. Out-of-range reads return 1.
  - When maze_oe is low, maze_in holds its last value.
  - Write: if maze_we is high, path[row][col] = 1.
  - visited_cnt increments only if that cell's path bit was 0 before the edge; out-of-range writes are dropped.
  - oe and we in the same cycle on the same cell: both take effect. The read returns the wall bit (unaffected by path).
  - done high in RUN with exit_found = 0: latch exit_row = row, exit_col = col, exit_found = 1. Later done pulses are ignored (sticky).
  - RUN persists until reset. There is no return to LOAD.
- Outside RUN: maze_oe and maze_we have no effect, and maze_in is forced to 1 (the solver sees walls everywhere).
- Reset asserted mid-RUN or mid-CLEAR: all outputs return to reset values immediately. CLEAR restarts from (0,0) on reset release.
- visited_cnt width: 13 bits, saturating at 4096. It cannot overflow for a 64x64 map.

Test Plan:
- Reset release, N_ROWS = N_COLS = 64 -> mem_ready rises exactly 4096 cycles later. dbg_path = 0 at (0,0), (63,63) and (17,42).
- LOAD wall=1 at (5,5); start; then oe at (5,5) and at (5,6) in consecutive cycles -> maze_in = 1, then 0, each one cycle after its oe.
- RUN: we at (10,10) three times, plus one we at (10,11) -> visited_cnt = 2; dbg_path = 1 at both cells.
- N_ROWS = 8: oe at row 8 -> maze_in = 1. we at (8,0) -> visited_cnt unchanged; dbg_path(8,0) = 0.
- done with (0,33), then done with (63,1) -> exit_found = 1, exit_row = 0, exit_col = 33 retained.
- Assert rst_n low mid-RUN with visited_cnt = 5 -> visited_cnt = 0, running = 0, maze_in = 1 immediately. After release, CLEAR runs the full 4096 cycles and path cells read 0.
